// File: rtl/uart_resp_framer.sv
// Response framer: drains the read-back FIFO and sends each PAYLOAD_LEN-byte group to the
// UART as HDR0, HDR1, LEN, payload, CSUM with one send/done handshake per byte.
module uart_resp_framer #(
   parameter int unsigned PAYLOAD_LEN = 4,
   parameter logic [7:0]  HDR0        = 8'h55,
   parameter logic [7:0]  HDR1        = 8'hAA,
   parameter int unsigned TIMEOUT     = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rfifo_empty,
   output logic       rfifo_rd_en,
   input  logic [7:0] rfifo_rd_data,
   output logic       tx_send_en,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic       frame_done,
   output logic       underrun,
   output logic [7:0] frame_cnt
);

   localparam int unsigned    WCW  = $clog2(TIMEOUT + 1);
   localparam logic [7:0]     LEN  = 8'(PAYLOAD_LEN);
   localparam logic [7:0]     LAST = 8'(PAYLOAD_LEN - 1);
   localparam logic [WCW-1:0] TO_W = WCW'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_FETCH, S_CAPT} state_t;
   typedef enum logic [2:0] {B_HDR0, B_HDR1, B_LEN, B_PAY, B_CSUM} byte_t;

   state_t         r_state, w_state;
   byte_t          r_phase, w_phase;
   logic [7:0]     r_pay_cnt, w_pay_cnt;
   logic [WCW-1:0] r_wait_cnt, w_wait_cnt;
   logic [7:0]     r_csum, w_csum;
   logic           r_under, w_under;
   logic           r_send, w_send;
   logic [7:0]     r_data, w_data;
   logic           r_fdone, w_fdone;
   logic           r_urun, w_urun;
   logic [7:0]     r_fcnt, w_fcnt;

   assign rfifo_rd_en = (r_state == S_FETCH) && !rfifo_empty;
   assign tx_send_en  = r_send;
   assign tx_data     = r_data;
   assign frame_done  = r_fdone;
   assign underrun    = r_urun;
   assign frame_cnt   = r_fcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_phase    <= B_HDR0;
         r_pay_cnt  <= '0;
         r_wait_cnt <= '0;
         r_csum     <= '0;
         r_under    <= 1'b0;
         r_send     <= 1'b0;
         r_data     <= '0;
         r_fdone    <= 1'b0;
         r_urun     <= 1'b0;
         r_fcnt     <= '0;
      end else begin
         r_state    <= w_state;
         r_phase    <= w_phase;
         r_pay_cnt  <= w_pay_cnt;
         r_wait_cnt <= w_wait_cnt;
         r_csum     <= w_csum;
         r_under    <= w_under;
         r_send     <= w_send;
         r_data     <= w_data;
         r_fdone    <= w_fdone;
         r_urun     <= w_urun;
         r_fcnt     <= w_fcnt;
      end
   end

   // Every transition into SEND also loads the byte, so tx_send_en is registered with it.
   always_comb begin
      w_state    = r_state;
      w_phase    = r_phase;
      w_pay_cnt  = r_pay_cnt;
      w_wait_cnt = r_wait_cnt;
      w_csum     = r_csum;
      w_under    = r_under;
      w_send     = 1'b0;
      w_data     = r_data;
      w_fdone    = 1'b0;
      w_urun     = 1'b0;
      w_fcnt     = r_fcnt;
      case (r_state)
         S_IDLE: begin
            if (!rfifo_empty) begin
               w_state   = S_SEND;
               w_phase   = B_HDR0;
               w_send    = 1'b1;
               w_data    = HDR0;
               w_pay_cnt = '0;
               w_csum    = '0;
               w_under   = 1'b0;
            end
         end
         S_SEND: w_state = S_WAIT;
         S_WAIT: begin
            if (tx_done) begin
               case (r_phase)
                  B_HDR0: begin
                     w_state = S_SEND;
                     w_phase = B_HDR1;
                     w_send  = 1'b1;
                     w_data  = HDR1;
                  end
                  B_HDR1: begin
                     w_state = S_SEND;
                     w_phase = B_LEN;
                     w_send  = 1'b1;
                     w_data  = LEN;
                  end
                  B_LEN: begin
                     w_state    = S_FETCH;
                     w_phase    = B_PAY;
                     w_wait_cnt = '0;
                  end
                  B_PAY: begin
                     if (r_pay_cnt == LAST) begin
                        w_state = S_SEND;
                        w_phase = B_CSUM;
                        w_send  = 1'b1;
                        w_data  = r_csum + LEN;
                     end else begin
                        w_state    = S_FETCH;
                        w_pay_cnt  = r_pay_cnt + 8'd1;
                        w_wait_cnt = '0;
                     end
                  end
                  B_CSUM: begin
                     w_state = S_IDLE;
                     w_fdone = 1'b1;
                     w_urun  = r_under;
                     w_fcnt  = r_fcnt + 8'd1;
                  end
                  default: w_state = S_IDLE;
               endcase
            end
         end
         S_FETCH: begin
            if (!rfifo_empty) begin
               w_state = S_CAPT;
            end else if (r_wait_cnt >= TO_W) begin
               w_state = S_SEND;
               w_send  = 1'b1;
               w_data  = '0;
               w_under = 1'b1;
            end else begin
               w_wait_cnt = r_wait_cnt + WCW'(1);
            end
         end
         S_CAPT: begin
            w_state = S_SEND;
            w_send  = 1'b1;
            w_data  = rfifo_rd_data;
            w_csum  = r_csum + rfifo_rd_data;
         end
         default: w_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_resp_framer.sv
// Bench for uart_resp_framer: one cycle-stepped process plays the read FIFO and the UART
// transmitter and compares every framed byte, handshake timing and status output to a frame model.
module tb_uart_resp_framer;
   localparam int PL = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst, rfifo_empty, rfifo_rd_en, tx_send_en, tx_done, frame_done, underrun;
   logic [7:0] rfifo_rd_data, tx_data, frame_cnt;

   always #5 clk = ~clk;

   uart_resp_framer #(.PAYLOAD_LEN(PL), .HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rfifo_empty(rfifo_empty), .rfifo_rd_en(rfifo_rd_en),
      .rfifo_rd_data(rfifo_rd_data), .tx_send_en(tx_send_en), .tx_data(tx_data),
      .tx_done(tx_done), .frame_done(frame_done), .underrun(underrun), .frame_cnt(frame_cnt)
   );

   int         n_chk = 0, n_pass = 0, cyc = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         lat_q[$];
   bit         fd_q[$];
   bit         pend_pop, busy, spur_send, spur_idle, gap_rand, prev_empty;
   int         done_at, busy_pos, pos, last_done, csum_done, fall_cyc, gap_until, gap_pos;
   int         dly_min, dly_max, n_fr;
   logic [7:0] busy_byte;
   logic [31:0] w;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Frame model: header, LEN, payload (pads after nreal), checksum = LEN + payload mod 256.
   task automatic expect_frame(input logic [8*PL-1:0] pw, input int nreal, input int first_lat,
                               input bit chk_pay);
      int s = PL;
      logic [7:0] b;
      exp_q.push_back(8'h55);   lat_q.push_back(first_lat);
      exp_q.push_back(8'hAA);   lat_q.push_back(1);
      exp_q.push_back(8'(PL));  lat_q.push_back(1);
      for (int i = 0; i < PL; i++) begin
         b = (i < nreal) ? pw[8*(PL-1-i) +: 8] : 8'h00;
         s += int'(b);
         exp_q.push_back(b);
         lat_q.push_back((i >= nreal) ? TO + 2 : (chk_pay ? 3 : -1));
      end
      exp_q.push_back(8'(s % 256)); lat_q.push_back(1);
      fd_q.push_back(nreal < PL);
   endtask

   task automatic load(input logic [8*PL-1:0] pw, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(pw[8*(PL-1-i) +: 8]);
   endtask

   task automatic on_send();
      int lat;
      check("send_expected", 32'(exp_q.size() != 0), 1);
      check("send_while_busy", 32'(busy), 0);
      if (exp_q.size() != 0) begin
         lat = lat_q.pop_front();
         if (lat == -2) check("start_latency", cyc - fall_cyc, 1);
         else if (lat > 0) check("send_latency", cyc - last_done, lat);
         check("tx_data", tx_data, exp_q.pop_front());
      end
      busy      = 1'b1;
      busy_byte = tx_data;
      busy_pos  = pos;
      pos       = (pos == PL + 3) ? 0 : pos + 1;
      done_at   = cyc + $urandom_range(dly_max, dly_min);
   endtask

   // One clock cycle: observe outputs at the falling edge, then drive the next inputs.
   task automatic tick();
      @(negedge clk);
      cyc++;
      tx_done = 1'b0;
      if (pend_pop) rfifo_rd_data = fifo_q.pop_front();
      if (tx_send_en) begin
         on_send();
         if (spur_send) tx_done = 1'b1;
      end
      if (frame_done) begin
         check("fd_expected", 32'(fd_q.size() != 0), 1);
         check("fd_timing", cyc - csum_done, 1);
         if (fd_q.size() != 0) check("underrun", underrun, fd_q.pop_front());
         n_fr++;
         check("frame_cnt", frame_cnt, n_fr % 256);
      end else begin
         check("underrun_alone", underrun, 0);
      end
      if (busy && cyc == done_at) begin
         check("tx_data_hold", tx_data, busy_byte);
         tx_done   = 1'b1;
         busy      = 1'b0;
         last_done = cyc;
         if (busy_pos == PL + 3) csum_done = cyc;
         if (busy_pos >= 2 && busy_pos <= PL + 1) begin
            if (busy_pos == gap_pos) gap_until = cyc + 6;
            else if (gap_rand && $urandom_range(1, 0) == 1) gap_until = cyc + 1 + $urandom_range(10, 1);
         end
      end
      if (spur_idle) begin
         tx_done   = 1'b1;
         spur_idle = 1'b0;
      end
      rfifo_empty = (fifo_q.size() == 0) || (cyc < gap_until);
      if (prev_empty && !rfifo_empty) fall_cyc = cyc;
      prev_empty = rfifo_empty;
      #1;
      if (rfifo_empty) check("rd_en_while_empty", rfifo_rd_en, 0);
      pend_pop = rfifo_rd_en && !rfifo_empty;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while ((exp_q.size() != 0 || fd_q.size() != 0 || busy) && n < maxc) begin
         tick();
         n++;
      end
      check("drain_done", exp_q.size() + fd_q.size() + int'(busy), 0);
      repeat (3) tick();
   endtask

   task automatic check_reset_outputs();
      check("rst_tx_send_en", tx_send_en, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_underrun", underrun, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_rd_en", rfifo_rd_en, 0);
   endtask

   initial begin
      rst = 1'b1; rfifo_empty = 1'b1; tx_done = 1'b0; rfifo_rd_data = '0;
      pend_pop = 0; busy = 0; spur_send = 0; spur_idle = 0; gap_rand = 0; prev_empty = 1;
      pos = 0; busy_pos = 0; done_at = 0; last_done = 0; csum_done = 0; fall_cyc = 0;
      gap_until = 0; gap_pos = -1; dly_min = 10; dly_max = 10; n_fr = 0; busy_byte = '0;
      repeat (3) tick();
      check_reset_outputs();
      rst = 1'b0;
      tick();

      // single frame, CSUM AE
      load(32'h11223344, 4);
      expect_frame(32'h11223344, 4, -2, 1'b1);
      drain(600);

      // checksum wrap to 00, back to back
      load(32'hFFFFFFFF, 4); load(32'h000000FC, 4);
      expect_frame(32'hFFFFFFFF, 4, -2, 1'b1);
      expect_frame(32'h000000FC, 4, 2, 1'b1);
      drain(1200);

      // back to back 01..08, CSUMs 0E and 1E
      load(32'h01020304, 4); load(32'h05060708, 4);
      expect_frame(32'h01020304, 4, -2, 1'b1);
      expect_frame(32'h05060708, 4, 2, 1'b1);
      drain(1200);

      // underrun: two real bytes then two pads, CSUM 7C
      load(32'hABCD0000, 2);
      expect_frame(32'hABCD0000, 2, -2, 1'b1);
      drain(1200);

      // spurious tx_done in IDLE and SEND, 5-cycle FIFO gap before payload[1]
      spur_idle = 1'b1;
      repeat (6) tick();
      spur_send = 1'b1; gap_pos = 3;
      load(32'hDEADBEEF, 4);
      expect_frame(32'hDEADBEEF, 4, -2, 1'b0);
      drain(1200);
      spur_send = 1'b0; gap_pos = -1;

      // randomized frames with random handshake delay and short FIFO gaps
      dly_min = 1; dly_max = 12; gap_rand = 1'b1; spur_send = 1'b1;
      for (int f = 0; f < 6; f++) begin
         w = $urandom();
         load(w, 4);
         expect_frame(w, 4, (f == 0) ? -2 : 2, 1'b0);
      end
      drain(6 * 500);
      dly_min = 10; dly_max = 10; gap_rand = 1'b0; spur_send = 1'b0;

      // reset during payload[1] WAIT
      load(32'h5A6B7C8D, 4);
      expect_frame(32'h5A6B7C8D, 4, -2, 1'b1);
      for (int n = 0; n < 300 && !(busy && busy_pos == 4); n++) tick();
      check("reached_payload1", 32'(busy && busy_pos == 4), 1);
      repeat (2) tick();
      exp_q.delete(); lat_q.delete(); fd_q.delete(); fifo_q.delete();
      busy = 1'b0; pend_pop = 1'b0; pos = 0; n_fr = 0;
      rst = 1'b1;
      tick();
      check_reset_outputs();
      rst = 1'b0;
      repeat (2) tick();
      load(32'hC3D4E5F6, 4);
      expect_frame(32'hC3D4E5F6, 4, -2, 1'b1);
      drain(600);
      check("cnt_after_reset", frame_cnt, 1);

      // frame_cnt wraps 255 -> 0
      dly_min = 1; dly_max = 1;
      for (int f = 0; f < 255; f++) begin
         w = $urandom();
         load(w, 4);
         expect_frame(w, 4, (f == 0) ? -2 : 2, 1'b1);
      end
      drain(255 * 40);
      check("final_frame_cnt", frame_cnt, n_fr % 256);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_resp_framer.md
# uart_resp_framer

Response framer between the read-back FIFO (8x16, normal-mode q) and the UART byte transmitter. It drains SDRAM read data from the read FIFO and wraps each group of PAYLOAD_LEN bytes into a framed packet: two header bytes, length, payload, then an 8-bit checksum. Bytes are handed to the transmitter one at a time with a send/done handshake. This replaces direct FIFO-to-UART draining, so the host can delimit and verify read responses.

## Interface
- PAYLOAD_LEN, 4: payload bytes per frame, 1..255
- HDR0, 8'h55: first header byte
- HDR1, 8'hAA: second header byte
- TIMEOUT, 5000: clk cycles to wait on an empty FIFO mid-frame before padding, ≥1

One clock; reset is synchronous and active-high.

- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous active-high reset
- rfifo_empty  in  1  read FIFO empty flag
- rfifo_rd_en  out  1  read FIFO read request (combinational)
- rfifo_rd_data  in  8  read FIFO q, valid the cycle after rfifo_rd_en
- tx_send_en  out  1  one-cycle pulse: start transmitting tx_data
- tx_data  out  8  byte to transmit, held stable until tx_done
- tx_done  in  1  one-cycle pulse: transmitter finished current byte
- frame_done  out  1  one-cycle pulse after the checksum byte's tx_done
- underrun  out  1  one-cycle pulse, coincident with frame_done, if any pad byte was inserted
- frame_cnt  out  8  completed frames, wraps 255→0

## Operation
- Frame byte order: HDR0, HDR1, LEN (= PAYLOAD_LEN[7:0]), payload[0..PAYLOAD_LEN-1], CSUM.
- CSUM = (LEN + sum of payload bytes, including pads) mod 256. No header bytes in CSUM.
- States:
  - IDLE: leaves to SEND(HDR0) when rfifo_empty==0.
  - SEND: pulses tx_send_en, goes to WAIT.
  - WAIT: waits for tx_done, then picks the next byte. Header/LEN go to SEND with the next fixed byte. Payload goes to FETCH while bytes remain, else SEND(CSUM). After CSUM it goes to IDLE and pulses frame_done.
  - FETCH: if !rfifo_empty, rfifo_rd_en=1, go to CAPT. If empty, increment the wait counter; when it reaches TIMEOUT, load pad 8'h00, set the underrun sticky flag, and go to SEND.
  - CAPT: latch rfifo_rd_data into tx_data, add it to CSUM, go to SEND.
- rfifo_rd_en = (state==FETCH) && !rfifo_empty. It is never asserted in any other state.
- The wait counter clears on entry to FETCH.
- The payload counter counts 0..PAYLOAD_LEN-1. The checksum accumulator and the underrun sticky flag clear on leaving IDLE.
- tx_done is ignored in all states except WAIT.
- Reset mid-frame: abandon the frame, clear all state. Bytes already popped are lost; the FIFO contents are untouched.

## Timing
- Reset values:
  - state IDLE
  - rfifo_rd_en=0, tx_send_en=0, tx_data=8'h00
  - frame_done=0, underrun=0, frame_cnt=0
- Registered outputs: tx_send_en, tx_data, frame_done, underrun, frame_cnt. rfifo_rd_en is combinational from state and rfifo_empty.
- Frame start: rfifo_empty sampled 0 in IDLE at edge N. Then tx_send_en=1 with tx_data=HDR0 in cycle N+1.
- Header/LEN/CSUM bytes: tx_done in cycle M gives tx_send_en=1 in cycle M+1.
- Payload byte with FIFO non-empty:
  - tx_done in cycle M
  - FETCH in M+1 (rfifo_rd_en=1)
  - CAPT in M+2
  - tx_send_en in M+3
- Pad byte: tx_send_en comes TIMEOUT+1 cycles after FETCH entry if the FIFO stays empty. A byte arriving before the timeout is read normally.
- frame_done, underrun, and the frame_cnt increment all occur in the cycle after the CSUM tx_done.
- A back-to-back frame starts at IDLE the cycle after that: first tx_send_en 2 cycles after the CSUM tx_done.
- tx_data changes only when tx_send_en is asserted.

## Test plan
- Single frame: FIFO holds 11 22 33 44, tx_done returned 10 cycles after each send → UART sees 55 AA 04 11 22 33 44 AE. One frame_done, underrun=0, frame_cnt=1.
- Checksum wrap: payload FF FF FF FF → CSUM 00. Payload 00 00 00 FC → CSUM 00.
- Underrun: FIFO holds AB CD only, TIMEOUT=16 → 55 AA 04 AB CD 00 00 7C. underrun pulses with frame_done. rfifo_rd_en is never asserted while empty.
- Back-to-back: 8 bytes 01..08 queued → two frames, CSUMs 0E and 1E. frame_cnt=2. Second HDR0 send_en exactly 2 cycles after the first CSUM tx_done.
- Handshake robustness: spurious tx_done pulses in IDLE and in SEND are ignored (no extra bytes, no state change). The FIFO goes empty for 5 cycles mid-payload with TIMEOUT=16 → no pad, correct data.
- Reset mid-frame: assert rst during the payload[1] WAIT → next cycle all outputs at reset values. After release, a new frame of 4 fresh bytes transmits correctly with frame_cnt=1.
